// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron multiply-accumulate stage.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mac_state_t;

  localparam int DEF_PIX_W = 8;
  localparam int DEF_WGT_W = 8;
  localparam int DEF_ACC_W = 24;

  // Saturation limits for a w-bit signed accumulator, in the low w bits.
  function automatic logic [63:0] acc_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] acc_min(input int w);
    return ~acc_max(w);
  endfunction

  localparam logic [DEF_ACC_W-1:0] ACC_MAX = DEF_ACC_W'(acc_max(DEF_ACC_W));
  localparam logic [DEF_ACC_W-1:0] ACC_MIN = DEF_ACC_W'(acc_min(DEF_ACC_W));

endpackage

// File: rtl/fullAdder.sv
// One-bit full adder cell used by the ripple adder chain.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// W-bit ripple-carry adder built from fullAdder cells; exposes the MSB carries
// so the caller can detect signed overflow (carry-in xor carry-out of the MSB).
module ripple_adder #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         c_msb_in,
  output logic         c_msb_out
);

  logic [W:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fullAdder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign c_msb_in  = carry[W-1];
  assign c_msb_out = carry[W];

endmodule

// File: rtl/neuron_mac.sv
// Serial shift-and-add MAC for one neuron: one pixel bit per cycle, sum
// presented over valid/ready. Define NEURON_MAC_SAT_EN for saturating adds.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends combinationally on ready, and ready on valid.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int WGT_W = DEF_WGT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic [WGT_W-1:0] in_weight,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output mac_state_t       dbg_state
);

  localparam int CNT_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;

  mac_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [PIX_W-1:0] pix_q;
  logic [WGT_W-1:0] wgt_q;
  logic             last_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;

  logic [ACC_W-1:0] wgt_ext;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] add_sum;
  logic             add_c_in;
  logic             add_c_out;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;
  logic             last_bit;

  // ACC_W >= PIX_W + WGT_W, so the shifted weight never loses bits.
  assign wgt_ext  = {{(ACC_W-WGT_W){wgt_q[WGT_W-1]}}, wgt_q};
  assign addend   = pix_q[cnt_q] ? (wgt_ext << cnt_q) : '0;
  assign last_bit = (cnt_q == CNT_W'(PIX_W - 1));

  ripple_adder #(.W(ACC_W)) u_add (
    .a         (acc_q),
    .b         (addend),
    .sum       (add_sum),
    .c_msb_in  (add_c_in),
    .c_msb_out (add_c_out)
  );

  assign add_ovf = add_c_in ^ add_c_out;

`ifdef NEURON_MAC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min(ACC_W));

  // Overflow only happens when both operands share acc's sign.
  always_comb begin
    acc_next = add_sum;
    ovf_next = ovf_q | add_ovf;
    if (add_ovf) begin
      acc_next = acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  assign out_ovf = ovf_q;
`else
  logic unused_ovf;

  assign unused_ovf = add_ovf;
  assign acc_next   = add_sum;
  assign ovf_next   = 1'b0;
  assign out_ovf    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MUL;
      MUL:     if (last_bit) state_d = last_q ? DONE : IDLE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pix_q   <= '0;
      wgt_q   <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            pix_q  <= in_pixel;
            wgt_q  <= in_weight;
            last_q <= in_last;
            cnt_q  <= '0;
          end
        end
        MUL: begin
          acc_q <= acc_next;
          ovf_q <= ovf_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        DONE: begin
          if (out_ready) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac (ACC_W=16) against a per-sum arithmetic model.
module tb_neuron_mac;
  import neuron_pkg::*;

  localparam int PW = 8;
  localparam int WW = 8;
  localparam int AW = 16;
  localparam longint SMAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (AW - 1));

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_pixel = '0;
  logic [WW-1:0] in_weight = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_sum;
  logic          out_ovf;
  mac_state_t    dbg_state;

  neuron_mac #(.PIX_W(PW), .WGT_W(WW), .ACC_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .in_weight (in_weight),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [AW-1:0] exp_q[$];
  bit            exp_ovf_q[$];
  longint        m_acc = 0;
  bit            m_ovf = 1'b0;
  longint        last_exp = 0;
  bit            last_exp_ovf = 1'b0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Product added bit by bit, since saturation clamps each partial add.
  function automatic void model_add(input int p, input int w);
    longint t;
    logic signed [AW-1:0] tw;
    for (int i = 0; i < PW; i++) begin
      if (((p >> i) & 1) == 1) begin
        t = m_acc + longint'(w) * (longint'(1) << i);
`ifdef NEURON_MAC_SAT_EN
        if (t > SMAX) begin
          t = SMAX;
          m_ovf = 1'b1;
        end else if (t < SMIN) begin
          t = SMIN;
          m_ovf = 1'b1;
        end
`endif
        tw = t[AW-1:0];
        m_acc = longint'(tw);
      end
    end
  endfunction

  // Compare process: every cycle the sum is offered, it must match the model.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("out_sum", longint'($signed(out_sum)), longint'($signed(exp_q[0])));
        check("out_ovf", longint'(out_ovf), longint'(exp_ovf_q[0]));
        check("in_ready_in_done", longint'(in_ready), 0);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_ovf_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pair(input int p, input int w, input bit last);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 0, 1);
    in_valid  = 1'b1;
    in_pixel  = PW'(p);
    in_weight = WW'(w);
    in_last   = last;
    @(posedge clk);
    #1;
    model_add(p, w);
    if (last) begin
      last_exp     = m_acc;
      last_exp_ovf = m_ovf;
      exp_q.push_back(AW'(m_acc));
      exp_ovf_q.push_back(m_ovf);
      m_acc = 0;
      m_ovf = 1'b0;
    end
    // Busy window: inputs are noise and must be ignored.
    in_valid  = 1'($urandom_range(0, 1));
    in_pixel  = PW'($urandom);
    in_weight = WW'($urandom);
    in_last   = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < PW; i++) begin
      @(negedge clk);
      check("busy_in_ready", longint'(in_ready), 0);
      check("busy_out_valid", longint'(out_valid), 0);
      if (i == PW - 1) begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
      end
    end
    @(negedge clk);
    if (last) begin
      check("done_out_valid", longint'(out_valid), 1);
      check("done_in_ready", longint'(in_ready), 0);
    end else begin
      check("next_in_ready", longint'(in_ready), 1);
      check("next_out_valid", longint'(out_valid), 0);
    end
  endtask

  // Called at a negedge where out_valid is high; stalls, then takes the sum.
  task automatic collect(input int hold);
    logic [AW-1:0] s0;
    logic          o0;
    s0 = out_sum;
    o0 = out_ovf;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("hold_out_valid", longint'(out_valid), 1);
      check("hold_in_ready", longint'(in_ready), 0);
      check("hold_out_sum", longint'(out_sum), longint'(s0));
      check("hold_out_ovf", longint'(out_ovf), longint'(o0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_hs_out_valid", longint'(out_valid), 0);
    check("post_hs_in_ready", longint'(in_ready), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_acc = 0;
    m_ovf = 1'b0;
    exp_q.delete();
    exp_ovf_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int npairs;
    int p;
    int w;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_sum", longint'(out_sum), 0);
    check("rst_out_ovf", longint'(out_ovf), 0);
    check("rst_state", longint'(dbg_state), longint'(IDLE));

    send_pair(3, 5, 1'b1);
    check("model_3x5", last_exp, 15);
    check("lit_3x5", longint'($signed(out_sum)), 15);
    collect(0);

    send_pair(255, -128, 1'b1);
    check("model_255xm128", last_exp, -32640);
    check("lit_255xm128", longint'($signed(out_sum)), -32640);
    collect(1);

    send_pair(10, 2, 1'b0);
    send_pair(20, -3, 1'b0);
    send_pair(0, 7, 1'b1);
    check("model_seq", last_exp, -40);
    check("lit_seq", longint'($signed(out_sum)), -40);
    collect(5);

    send_pair(1, 1, 1'b1);
    check("lit_after_clear", longint'($signed(out_sum)), 1);
    collect(0);

    send_pair(255, 127, 1'b0);
    send_pair(255, 127, 1'b0);
    send_pair(255, 127, 1'b1);
`ifdef NEURON_MAC_SAT_EN
    check("model_sat", last_exp, 32767);
    check("model_sat_ovf", longint'(last_exp_ovf), 1);
    check("lit_sat", longint'($signed(out_sum)), 32767);
    check("lit_sat_ovf", longint'(out_ovf), 1);
`else
    check("model_wrap", last_exp, 31619);
    check("model_wrap_ovf", longint'(last_exp_ovf), 0);
    check("lit_wrap", longint'($signed(out_sum)), 31619);
    check("lit_wrap_ovf", longint'(out_ovf), 0);
`endif
    collect(2);

    // Reset in the 4th MUL cycle discards the partial sum.
    @(negedge clk);
    in_valid  = 1'b1;
    in_pixel  = PW'(200);
    in_weight = WW'(-77);
    in_last   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    @(negedge clk);
    check("mid_rst_in_ready", longint'(in_ready), 1);
    check("mid_rst_out_valid", longint'(out_valid), 0);
    send_pair(2, 3, 1'b1);
    check("lit_after_rst", longint'($signed(out_sum)), 6);
    collect(0);

    // Randomized sums of 1..4 pairs with edge-biased operands.
    for (int s = 0; s < 30; s++) begin
      npairs = $urandom_range(1, 4);
      for (int k = 0; k < npairs; k++) begin
        case ($urandom_range(0, 3))
          0:       p = 255;
          1:       p = 0;
          default: p = $urandom_range(0, 255);
        endcase
        case ($urandom_range(0, 3))
          0:       w = -128;
          1:       w = 127;
          default: w = $urandom_range(0, 255) - 128;
        endcase
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        send_pair(p, w, (k == npairs - 1));
      end
      collect($urandom_range(0, 3));
    end

    @(negedge clk);
    check("queue_drained", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Serial multiply-accumulate stage for one MLP neuron: accepts a stream of (pixel, weight) pairs, forms each product by shift-and-add over the pixel bits, and accumulates the products into a signed sum. It sits downstream of the bit-level adder datapath (ripple adder built from `fullAdder` cells) and upstream of the activation stage. It presents the finished weighted sum over a valid/ready handshake.

## Interface
- `PIX_W`, default 8: unsigned pixel width; also the number of multiply cycles per pair.
- `WGT_W`, default 8: signed two's-complement weight width.
- `ACC_W`, default 24: signed accumulator and output width. Must satisfy ACC_W ≥ PIX_W + WGT_W.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: pair present.
- `in_ready` output 1: block can accept a pair; equals (state == IDLE).
- `in_pixel` input PIX_W: unsigned multiplier.
- `in_weight` input WGT_W: signed multiplicand.
- `in_last` input 1: pair is the final term of the current sum.
- `out_valid` output 1: finished sum available.
- `out_ready` input 1: consumer accepts the sum.
- `out_sum` output ACC_W: signed weighted sum.
- `out_ovf` output 1: overflow or saturation occurred during this sum.

## Operation
- State machine with three states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, capture pixel, weight and last into registers, clear the bit counter, and go to MUL.
  - MUL: on each of exactly PIX_W cycles, for bit i (LSB first), if pixel[i]=1 then acc ← acc + (sext(weight) << i); otherwise acc is unchanged. After the cycle processing bit PIX_W−1, go to DONE if last=1, else go to IDLE.
  - DONE: `out_valid`=1 and `out_sum`=acc. On `out_valid`&&`out_ready`: clear acc to 0, clear `out_ovf`, and go to IDLE.
- Arithmetic: the weight is sign-extended to ACC_W before shifting. The pixel is treated as unsigned. Without saturation, all adds wrap modulo 2^ACC_W.
- A pixel of 0 still takes the full PIX_W cycles. There is no early exit.
- Between sums, acc persists across non-last pairs. It clears only on an output handshake or on reset.
- `in_*` inputs are ignored outside IDLE. `out_ready` is ignored outside DONE.

## Timing
- Reset values: state=IDLE, acc=0, counter=0, `out_valid`=0, `out_sum`=0, `out_ovf`=0. As a result, `in_ready`=1 in the first cycle after reset.
- Latency: pair accepted at edge 0 → its product is fully added at edge PIX_W.
  - If last: `out_valid` is high from edge PIX_W.
  - If not last: `in_ready` is high from edge PIX_W.
- Throughput: one pair per PIX_W+1 cycles. `in_ready` is low for exactly PIX_W cycles after each accept.
- Outputs are registered. `out_sum` and `out_ovf` hold stable while `out_valid`=1 and `out_ready`=0.
- Output handshake at edge k → `in_ready`=1 from edge k. The next sum starts from 0.
- Reset asserted during MUL or DONE: at the next edge, all registers return to their reset values and the partial sum is discarded.

## Configuration
- `NEURON_MAC_SAT_EN` defined:
  - Each add checks signed overflow. On overflow, acc clamps to +(2^(ACC_W−1)−1) or −2^(ACC_W−1).
  - `out_ovf` is set sticky until the output handshake.
  - Once clamped, later adds continue from the clamped value.
- `NEURON_MAC_SAT_EN` undefined: adds wrap and `out_ovf` is tied to 0.

## Structure
- Package `neuron_pkg` holds:
  - the `mac_state_t` enum (IDLE, MUL, DONE);
  - default widths PIX_W/WGT_W/ACC_W;
  - ACC_MAX/ACC_MIN saturation constants as functions of ACC_W.
- Sub-module `ripple_adder`: ACC_W-bit adder built as a chain of `fullAdder` instances, with Cin=0. It exposes the sum and the carry into and out of the MSB (used for overflow detection). `neuron_mac` instantiates one, fed by acc and the shifted weight.

## Test plan
- Reset, then pair (pixel=3, weight=5, last=1) → `out_valid` rises at edge 8 after accept; `out_sum`=15; `out_ovf`=0.
- Pair (pixel=255, weight=−128, last=1) → `out_sum`=−32640.
- Sequence (10,2), (20,−3), (0,7,last) → `in_ready` low for 8 cycles after each accept; `out_sum`=−40.
- Hold `out_ready`=0 for 5 cycles in DONE → `out_sum`/`out_valid` stable and `in_ready`=0. Raise `out_ready`, then send (1,1,last) → `out_sum`=1, confirming acc was cleared.
- With ACC_W=16, three pairs of (255,127), last on the third:
  - with `NEURON_MAC_SAT_EN`: `out_sum`=32767, `out_ovf`=1;
  - without it: `out_sum`=31619, `out_ovf`=0.
- Assert `reset` at the 4th MUL cycle → next cycle `in_ready`=1 and `out_valid`=0. Then send (2,3,last) → `out_sum`=6.
